// File: rtl/f1_light_seq.sv
// ----------------------------------------------------------------------------
// f1_light_seq
//
// Race-start light sequencer. A rising edge on `trigger` arms the sequence;
// each subsequent `tick` lights one more LED (bit 0 first, left-fill). Once
// every LED is lit, the sequencer samples `rand_dly` and holds for that many
// ticks (0 and 1 both mean one tick). It then extinguishes the bank and pulses
// `done` for one clkin cycle.
//
// Optional build macro: F1_REACT_TIME_EN
//   Adds a reaction-time stage after lights-out. The sequencer counts clkin
//   cycles until the player presses `react`. The count saturates at 16'hFFFF.
//   Pressing `react` early, while the lights are sequencing or holding,
//   latches `jump`.
//
// Ports:
//   clkin        in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   tick         in   one-cycle advance enable from the tick divider
//   trigger      in   start request (level, rising edge detected here)
//   rand_dly     in   hold time in ticks, sampled when the last LED lights
//   ledr         out  LED drive, bit 0 lights first
//   busy         out  high from trigger acceptance until lights-out
//   done         out  one-cycle pulse in the lights-out cycle
//   react        in   player button, rising-edge detected  (F1_REACT_TIME_EN)
//   react_time   out  clkin cycles from lights-out to press (F1_REACT_TIME_EN)
//   react_valid  out  one-cycle pulse with react_time       (F1_REACT_TIME_EN)
//   jump         out  early press seen, sticky until next start (F1_REACT_TIME_EN)
// ----------------------------------------------------------------------------
module f1_light_seq #(
    parameter int N_LED = 10,
    parameter int DLY_W = 7
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               trigger,
    input  logic [DLY_W-1:0]   rand_dly,
`ifdef F1_REACT_TIME_EN
    input  logic               react,
    output logic [15:0]        react_time,
    output logic               react_valid,
    output logic               jump,
`endif
    output logic [N_LED-1:0]   ledr,
    output logic               busy,
    output logic               done
);

`ifdef F1_REACT_TIME_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LIGHT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_REACT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LIGHT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
`endif

    state_t             r_state;
    logic [N_LED-1:0]   r_ledr;
    logic [DLY_W-1:0]   r_hold_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_trig_prev;

    logic               w_trig_edge;
    logic               w_last_led;
    logic               w_hold_last;

`ifdef F1_REACT_TIME_EN
    logic [15:0]        r_react_cnt;
    logic [15:0]        r_react_time;
    logic               r_react_valid;
    logic               r_react_prev;
    logic               r_jump;
    logic               w_react_edge;
`endif

    assign w_trig_edge = trigger & ~r_trig_prev;
    // The shift that fills the top LED is the one where all lower bits are already lit.
    assign w_last_led  = &r_ledr[N_LED-2:0];
    // A zero hold value behaves like one: lights go out on the first hold tick.
    assign w_hold_last = (r_hold_cnt <= DLY_W'(1));

`ifdef F1_REACT_TIME_EN
    assign w_react_edge = react & ~r_react_prev;
`endif

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ledr      <= {N_LED{1'b0}};
            r_hold_cnt  <= {DLY_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_trig_prev <= 1'b0;
`ifdef F1_REACT_TIME_EN
            r_react_cnt   <= 16'd0;
            r_react_time  <= 16'd0;
            r_react_valid <= 1'b0;
            r_react_prev  <= 1'b0;
            r_jump        <= 1'b0;
`endif
        end else begin
            r_trig_prev <= trigger;
            r_done      <= 1'b0;
`ifdef F1_REACT_TIME_EN
            r_react_prev  <= react;
            r_react_valid <= 1'b0;
            // A press before lights-out is a jump start; the sequence carries on.
            if (w_react_edge && ((r_state == ST_LIGHT) || (r_state == ST_HOLD))) begin
                r_jump <= 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    r_ledr <= {N_LED{1'b0}};
                    r_busy <= 1'b0;
                    // A tick coincident with the accepting edge is deliberately ignored.
                    if (w_trig_edge) begin
                        r_state <= ST_LIGHT;
                        r_busy  <= 1'b1;
`ifdef F1_REACT_TIME_EN
                        r_jump  <= 1'b0;
`endif
                    end
                end

                ST_LIGHT: begin
                    if (tick) begin
                        r_ledr <= {r_ledr[N_LED-2:0], 1'b1};
                        if (w_last_led) begin
                            r_hold_cnt <= rand_dly;
                            r_state    <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (tick) begin
                        if (w_hold_last) begin
                            r_ledr <= {N_LED{1'b0}};
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
`ifdef F1_REACT_TIME_EN
                            r_state     <= ST_REACT;
                            r_react_cnt <= 16'd0;
`else
                            r_state     <= ST_IDLE;
`endif
                        end else begin
                            r_hold_cnt <= r_hold_cnt - DLY_W'(1);
                        end
                    end
                end

`ifdef F1_REACT_TIME_EN
                ST_REACT: begin
                    // Cycle counter saturates so a very late press still reports a sane value.
                    if (r_react_cnt != 16'hFFFF) begin
                        r_react_cnt <= r_react_cnt + 16'd1;
                    end
                    if (w_react_edge) begin
                        r_react_time  <= r_react_cnt;
                        r_react_valid <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                    r_ledr  <= {N_LED{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ledr = r_ledr;
    assign busy = r_busy;
    assign done = r_done;

`ifdef F1_REACT_TIME_EN
    assign react_time  = r_react_time;
    assign react_valid = r_react_valid;
    assign jump        = r_jump;
`endif

endmodule

// File: tb/tb_f1_light_seq.sv
// ----------------------------------------------------------------------------
// tb_f1_light_seq
//
// Self-checking bench for f1_light_seq (N_LED=10, DLY_W=7). Expected LED,
// busy and done values are queued as each tick is driven. They are popped and
// compared once the DUT has registered the tick. Reaction-time checks are
// compiled in with F1_REACT_TIME_EN.
// ----------------------------------------------------------------------------
module tb_f1_light_seq;

    localparam int N  = 10;
    localparam int DW = 7;

    logic          clkin = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          trigger;
    logic [DW-1:0] rand_dly;
    logic [N-1:0]  ledr;
    logic          busy;
    logic          done;
`ifdef F1_REACT_TIME_EN
    logic          react;
    logic [15:0]   react_time;
    logic          react_valid;
    logic          jump;
`endif

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int done_exp  = 0;

    typedef struct {
        string        tag;
        logic [N-1:0] ledr;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb_q[$];

    f1_light_seq #(.N_LED(N), .DLY_W(DW)) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .tick        (tick),
        .trigger     (trigger),
        .rand_dly    (rand_dly),
`ifdef F1_REACT_TIME_EN
        .react       (react),
        .react_time  (react_time),
        .react_valid (react_valid),
        .jump        (jump),
`endif
        .ledr        (ledr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clkin = ~clkin;

    // Count every done pulse so spurious pulses (e.g. from reset) are caught.
    always @(negedge clkin) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one tick (called at a negedge), then pop and compare the expectation.
    task automatic do_tick(input string tag, input logic [N-1:0] e_ledr,
                           input logic e_busy, input logic e_done);
        exp_t e;
        e.tag  = tag;
        e.ledr = e_ledr;
        e.busy = e_busy;
        e.done = e_done;
        sb_q.push_back(e);
        tick = 1'b1;
        @(negedge clkin);
        tick = 1'b0;
        e = sb_q.pop_front();
        check_eq({e.tag, "_ledr"}, 32'(ledr), 32'(e.ledr));
        check_eq({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
        check_eq({e.tag, "_done"}, 32'(done), 32'(e.done));
        @(negedge clkin);
        if (e_done) check_eq({e.tag, "_done_1cyc"}, 32'(done), 32'd0);
        repeat (2) @(negedge clkin);
    endtask

    // Full start-to-lights-out run with optional disturbances.
    task automatic run_seq(input string name, input int dly, input int late_dly,
                           input int retrig_at, input int jump_at, input bit coincident,
                           input bit hold_trig, input int react_extra);
        logic [N-1:0] all_on;
        logic [N-1:0] e;
        int           v;
        int           eff;
        all_on   = '1;
        rand_dly = dly[DW-1:0];
        trigger  = 1'b1;
        if (coincident) tick = 1'b1;
        @(negedge clkin);
        tick = 1'b0;
        if (!hold_trig) trigger = 1'b0;
        check_eq({name, "_start_busy"}, 32'(busy), 32'd1);
        if (coincident) check_eq({name, "_coinc_ledr"}, 32'(ledr), 32'd0);
`ifdef F1_REACT_TIME_EN
        check_eq({name, "_jump_clr"}, 32'(jump), 32'd0);
`endif
        @(negedge clkin);
        for (int k = 1; k <= N; k++) begin
            v = (1 << k) - 1;
            e = v[N-1:0];
            do_tick($sformatf("%s_led%0d", name, k), e, 1'b1, 1'b0);
            if (k == retrig_at) begin
                trigger = 1'b1;
                @(negedge clkin);
                trigger = 1'b0;
                @(negedge clkin);
                check_eq({name, "_retrig_busy"}, 32'(busy), 32'd1);
            end
            if (k == jump_at) begin
`ifdef F1_REACT_TIME_EN
                react = 1'b1;
                @(negedge clkin);
                react = 1'b0;
                @(negedge clkin);
                check_eq({name, "_jump_set"}, 32'(jump), 32'd1);
`else
                @(negedge clkin);
`endif
            end
            if ((k == N) && (late_dly >= 0)) rand_dly = late_dly[DW-1:0];
        end
        eff = (dly <= 1) ? 1 : dly;
        for (int h = 1; h <= eff; h++) begin
            if (h < eff) begin
                do_tick($sformatf("%s_hold%0d", name, h), all_on, 1'b1, 1'b0);
            end else begin
                do_tick($sformatf("%s_out", name), {N{1'b0}}, 1'b0, 1'b1);
                done_exp++;
            end
        end
        // Now three negedges past the done cycle; idle further before the press.
        repeat (react_extra) @(negedge clkin);
`ifdef F1_REACT_TIME_EN
        react = 1'b1;
        @(negedge clkin);
        react = 1'b0;
        check_eq({name, "_rvalid"}, 32'(react_valid), 32'd1);
        v = 3 + react_extra;
        if (v > 65535) v = 65535;
        check_eq({name, "_rtime"}, 32'(react_time), 32'(v));
        @(negedge clkin);
        check_eq({name, "_rvalid_1cyc"}, 32'(react_valid), 32'd0);
`endif
    endtask

    initial begin
        #(10_000_000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] all_on;
        logic [N-1:0] e;
        int           v;
        int           sat_extra;
        all_on    = '1;
        sat_extra = 0;
`ifdef F1_REACT_TIME_EN
        sat_extra = 70000;
        react     = 1'b0;
`endif
        rst_n    = 1'b0;
        tick     = 1'b1;
        trigger  = 1'b0;
        rand_dly = 7'd3;

        // Reset held for two cycles with ticks running.
        repeat (2) @(negedge clkin);
        check_eq("rst_ledr", 32'(ledr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
`ifdef F1_REACT_TIME_EN
        check_eq("rst_jump", 32'(jump), 32'd0);
        check_eq("rst_rvalid", 32'(react_valid), 32'd0);
        check_eq("rst_rtime", 32'(react_time), 32'd0);
`endif
        rst_n = 1'b1;
        tick  = 1'b0;
        @(negedge clkin);

        // Ticks without a trigger leave everything dark.
        for (int i = 0; i < 3; i++) do_tick($sformatf("idle%0d", i), {N{1'b0}}, 1'b0, 1'b0);

        run_seq("run3",   3, -1, 0, 0, 1'b0, 1'b0, 0);
        run_seq("dly0",   0, -1, 0, 0, 1'b0, 1'b0, 0);
        run_seq("dly1",   1, -1, 0, 0, 1'b0, 1'b0, 0);
        run_seq("late50", 2, 50, 0, 0, 1'b0, 1'b0, 0);
        run_seq("coinc",  3, -1, 0, 0, 1'b1, 1'b0, 0);
        run_seq("retrig", 3, -1, 5, 0, 1'b0, 1'b0, 0);
        run_seq("jump",   2, -1, 0, 4, 1'b0, 1'b0, 247);

        // Trigger held high through lights-out must not restart.
        run_seq("held",   2, -1, 0, 0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) do_tick($sformatf("held_idle%0d", i), {N{1'b0}}, 1'b0, 1'b0);
        trigger = 1'b0;
        @(negedge clkin);
        run_seq("rearm",  3, -1, 0, 0, 1'b0, 1'b0, sat_extra);

        // Reset in HOLD with hold_cnt at 2: no done pulse may ever follow.
        rand_dly = 7'd3;
        trigger  = 1'b1;
        @(negedge clkin);
        trigger = 1'b0;
        @(negedge clkin);
        for (int k = 1; k <= N; k++) begin
            v = (1 << k) - 1;
            e = v[N-1:0];
            do_tick($sformatf("mh_led%0d", k), e, 1'b1, 1'b0);
        end
        do_tick("mh_hold1", all_on, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick  = 1'b1;
        @(negedge clkin);
        rst_n = 1'b1;
        tick  = 1'b0;
        check_eq("mh_rst_ledr", 32'(ledr), 32'd0);
        check_eq("mh_rst_busy", 32'(busy), 32'd0);
        check_eq("mh_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) do_tick($sformatf("mh_after%0d", i), {N{1'b0}}, 1'b0, 1'b0);

        check_eq("done_pulse_count", 32'(done_seen), 32'(done_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
- Race-start light sequencer that consumes the one-cycle `tick` pulse produced by the programmable clock-tick divider.
- On a start request it lights `N_LED` LEDs one per tick, left-fill. It then holds all LEDs on for a caller-supplied number of ticks (typically from the LFSR random source), then extinguishes them and pulses `done`.
- Drives the board LED bank. Its `done` pulse feeds the reaction-timer / display path.

Parameters:
- N_LED, 10, number of LEDs in the sequence (2..16)
- DLY_W, 7, width of the hold-delay input in ticks

Ports:
- clkin  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- tick  input  1  one-clkin-cycle enable pulse from the tick divider; the only event that advances the sequence
- trigger  input  1  start request, level; the rising edge is detected internally against its previous-cycle value
- rand_dly  input  DLY_W  hold time in ticks; sampled once, when the last LED lights
- ledr  output  N_LED  LED drive; bit 0 lights first
- busy  output  1  high from trigger acceptance until the cycle `done` is asserted
- done  output  1  one-cycle pulse, asserted in the cycle the LEDs go dark

Behaviour:
- Reset (rst_n=0 at clkin edge):
  - outputs: ledr=0, busy=0, done=0
  - internal: state=IDLE, hold_cnt=0, trigger history=0
  - Applies from any state, including mid-sequence; no done pulse is generated by reset.
- States: IDLE, LIGHT, HOLD, plus REACT when the optional feature is compiled in.
- IDLE:
  - ledr=0, busy=0.
  - On trigger rising edge (trigger=1, previous-cycle trigger=0): state<=LIGHT, busy<=1.
  - A tick in the same cycle as the trigger edge is ignored. The first LED lights on the first tick strictly after entry.
- LIGHT:
  - Each tick: ledr <= {ledr[N_LED-2:0],1'b1}.
  - On the tick that sets ledr to all-ones: hold_cnt <= rand_dly, state<=HOLD.
  - Latency: all LEDs lit after exactly N_LED ticks.
- HOLD:
  - Each tick: if hold_cnt<=1, then ledr<=0, done<=1, busy<=0, state<=IDLE (REACT when the feature is compiled in); else hold_cnt<=hold_cnt-1.
  - rand_dly=0 and rand_dly=1 both give a 1-tick hold. rand_dly=D≥1 gives a D-tick hold.
- done is a registered output, high for exactly one clkin cycle; it is 0 in all other cycles.
- trigger edges are ignored while busy=1, and are not queued. A trigger held high through the return to IDLE does not restart the sequence; a new 0→1 edge is required.
- Changes to rand_dly after the sampling tick have no effect.
- Cycles with tick=0 leave ledr, hold_cnt and state unchanged; there are no timeouts in clkin cycles.

Optional Feature:
- Macro: F1_REACT_TIME_EN
- With macro:
  - Extra ports: react (input, 1, player button, rising-edge detected); react_time (output, 16, clkin cycles from lights-out to press); react_valid (output, 1, one-cycle pulse); jump (output, 1).
  - After HOLD, state=REACT with counter cleared to 0. The counter increments each clkin cycle and saturates at 16'hFFFF.
  - On a react edge: react_time<=counter, react_valid<=1, state<=IDLE.
  - busy stays 0 in REACT, and trigger edges in REACT are ignored.
  - A react edge during LIGHT or HOLD sets jump<=1, which holds until the next accepted trigger or reset. The sequence continues regardless.
  - Reset values: react_time=0, react_valid=0, jump=0.
- Without macro: these ports and the REACT state do not exist, and HOLD returns directly to IDLE.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, ticks running → ledr=0, busy=0, done=0. Ticks without a trigger leave ledr=0.
- Normal run (N_LED=10, tick every 4 clkin, rand_dly=3):
  - trigger edge → ledr = 0x001, 0x003, … 0x3FF on ticks 1..10
  - LEDs dark and done=1 for 1 cycle on tick 13, same cycle busy→0
- Boundaries: rand_dly=0 and rand_dly=1 → lights out exactly 1 tick after 0x3FF.
  - rand_dly changed to 50 after 0x3FF is reached → no effect.
  - trigger edge coincident with a tick → ledr still 0x000 after that tick.
- Retrigger/hold: trigger pulsed at LED 5 → ignored, sequence completes normally. Trigger held high through done → no restart until released and reasserted.
- Reset mid-HOLD at hold_cnt=2 → next edge ledr=0, busy=0, and no done pulse ever appears.
- (F1_REACT_TIME_EN) react edge 250 cycles after done → react_time=250, react_valid one-cycle pulse.
  - react during LIGHT → jump=1, cleared by the next trigger edge.
  - No press for 70000 cycles → react_time=0xFFFF when the press comes.
